// File: rtl/rr_stream_mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
// Mode encodings are shared with the other muxes in this codebase.
package rr_stream_mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Index increment with wrap-around over n channels.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_stream_mux_arbiter.sv
// Combinational arbiter: fixed priority, round-robin from ptr, or forced select.
// Produces a one-hot grant and its binary index; no grant means grant == 0.
module rr_arbiter
  import rr_stream_mux_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int MODE       = MODE_RR
) (
  input  logic [NUM_INPUTS-1:0]         req,
  input  logic [$clog2(NUM_INPUTS)-1:0] ptr,
  input  logic                          force_en,
  input  logic [$clog2(NUM_INPUTS)-1:0] force_sel,
  output logic [NUM_INPUTS-1:0]         grant,
  output logic [$clog2(NUM_INPUTS)-1:0] grant_idx
);

  localparam int SW = $clog2(NUM_INPUTS);

  int   win;
  int   idx;
  logic found;

  always_comb begin
    win   = 0;
    idx   = 0;
    found = 1'b0;
    if (force_en) begin
      // Out-of-range force_sel never matches a channel, so it yields no grant.
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (force_sel == SW'(i) && req[i]) begin
          win   = i;
          found = 1'b1;
        end
      end
    end else if (MODE == MODE_FIXED) begin
      for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
        if (req[i]) begin
          win   = i;
          found = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < NUM_INPUTS; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
        for (int i = 0; i < NUM_INPUTS; i++) begin
          if (!found && idx == i && req[i]) begin
            win   = i;
            found = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_INPUTS; i++) grant[i] = found && (win == i);
    grant_idx = SW'(win);
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N:1 valid/ready stream mux with one registered output stage.
// Arbitration is round-robin, fixed priority, or forced by force_sel.
module rr_stream_mux
  import rr_stream_mux_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int MODE       = MODE_RR
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]       in_valid,
  output logic [NUM_INPUTS-1:0]       in_ready,
  input  logic                        force_en,
  input  logic [SEL_WIDTH-1:0]        force_sel,
  output logic [WIDTH-1:0]            out_data,
  output logic [SEL_WIDTH-1:0]        out_sel,
  output logic                        out_valid,
  input  logic                        out_ready
);

  if (SEL_WIDTH != $clog2(NUM_INPUTS) || NUM_INPUTS < 2) begin : g_param_check
    $fatal(1, "rr_stream_mux: SEL_WIDTH must equal $clog2(NUM_INPUTS) and NUM_INPUTS >= 2");
  end

  logic [NUM_INPUTS-1:0] grant;
  logic [SEL_WIDTH-1:0]  grant_idx;
  logic [SEL_WIDTH-1:0]  ptr_q;
  logic                  load;
  logic                  xfer;
  logic [WIDTH-1:0]      data_p0;

  logic [WIDTH-1:0]      data_p1;
  logic [SEL_WIDTH-1:0]  sel_p1;
  logic                  vld_p1;

  rr_arbiter #(
    .NUM_INPUTS (NUM_INPUTS),
    .MODE       (MODE)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .force_en  (force_en),
    .force_sel (force_sel),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Stage p0: arbitration and data select
  assign load     = !vld_p1 || out_ready;
  assign xfer     = load && (|grant);
  assign in_ready = (load && !reset) ? grant : '0;
  assign data_p0  = in_data[int'(grant_idx)*WIDTH +: WIDTH];

  // Stage p1: output register and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      sel_p1  <= '0;
      ptr_q   <= '0;
    end else if (load) begin
      vld_p1 <= xfer;
      if (xfer) begin
        data_p1 <= data_p0;
        sel_p1  <= grant_idx;
        if (MODE == MODE_RR) ptr_q <= SEL_WIDTH'(wrap_inc(int'(grant_idx), NUM_INPUTS));
      end
    end
  end

  assign out_data  = data_p1;
  assign out_sel   = sel_p1;
  assign out_valid = vld_p1;

endmodule
